// File: rtl/dff_nand_pkg.sv
// Shared constants for the NAND-built D flip-flop.
//   RESET_VALUE   : value Q takes after a rising edge with RST = 1
//   DEFAULT_WIDTH : default number of independent flop bits
package dff_nand_pkg;

  localparam logic RESET_VALUE   = 1'b0;
  localparam int   DEFAULT_WIDTH = 1;

endpackage

// File: rtl/nand_sr_latch.sv
// Single-bit gated D latch made from four NAND2 gates.
// Ports:
//   en : latch is transparent while en = 1 and holds while en = 0
//   d  : data input
//   q  : stored value
//   qn : complement of q
module nand_sr_latch (
  input  logic en,
  input  logic d,
  output logic q,
  output logic qn
);

  logic s_n;
  logic r_n;

  // Reusing s_n as the inverted data input saves the separate inverter:
  // with en = 1, ~(s_n & en) == d; with en = 0 both set/reset go inactive.
  assign s_n = ~(d & en);
  assign r_n = ~(s_n & en);

  // Cross-coupled storage pair. s_n and r_n are never both low, so the
  // pair always settles with qn == ~q.
  assign q  = ~(s_n & qn);
  assign qn = ~(r_n & q);

endmodule

// File: rtl/dff_nand.sv
// Positive-edge D flip-flop, WIDTH bits, built as a master-slave pair of
// NAND latches per bit, with a synchronous active-high reset folded into
// the data path ahead of the master latch.
// Ports:
//   CLK : clock, all state changes on the rising edge
//   RST : synchronous reset, active-high
//   CE  : clock enable, active-high (only with DFF_NAND_CE_EN defined;
//         RST overrides CE)
//   D   : data input
//   Q   : registered data
//   Qp  : complement of Q
// Build option: define DFF_NAND_CE_EN to add the CE port and the hold mux.
module dff_nand
  import dff_nand_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef DFF_NAND_CE_EN
  input  logic             CE,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qp
);

  logic clk_n;
  logic rst_n;

  // Inverted clock for the master: NAND with both inputs tied to CLK.
  assign clk_n = ~(CLK & CLK);
  assign rst_n = ~(RST & RST);

`ifdef DFF_NAND_CE_EN
  logic ce_n;
  assign ce_n = ~(CE & CE);
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic d_sel;
    logic dn;
    logic dn_inv;
    logic m_q;
    logic m_qn;

`ifdef DFF_NAND_CE_EN
    // NAND 2:1 mux: CE picks new data, otherwise recirculate Q.
    logic mux_a;
    logic mux_b;
    assign mux_a = ~(D[i] & CE);
    assign mux_b = ~(Q[i] & ce_n);
    assign d_sel = ~(mux_a & mux_b);
`else
    assign d_sel = D[i];
`endif

    if (RESET_VALUE == 1'b0) begin : g_rst_lo
      // dn = d_sel AND NOT RST
      assign dn_inv = ~(d_sel & rst_n);
      assign dn     = ~(dn_inv & dn_inv);
    end else begin : g_rst_hi
      // dn = d_sel OR RST, as NAND of the two complements
      assign dn_inv = ~(d_sel & d_sel);
      assign dn     = ~(dn_inv & rst_n);
    end

    nand_sr_latch u_master (
      .en (clk_n),
      .d  (dn),
      .q  (m_q),
      .qn (m_qn)
    );

    nand_sr_latch u_slave (
      .en (CLK),
      .d  (m_q),
      .q  (Q[i]),
      .qn (Qp[i])
    );
  end

endmodule

// File: tb/tb_dff_nand.sv
module tb_dff_nand;

  logic       clk;
  logic       rst;
`ifdef DFF_NAND_CE_EN
  logic       ce;
`endif
  logic [0:0] d1;
  logic [7:0] d8;
  logic [0:0] q1, qp1;
  logic [7:0] q8, qp8;

  int total = 0;
  int bad   = 0;

  dff_nand #(.WIDTH(1)) dut1 (
    .CLK (clk),
    .RST (rst),
`ifdef DFF_NAND_CE_EN
    .CE  (ce),
`endif
    .D   (d1),
    .Q   (q1),
    .Qp  (qp1)
  );

  dff_nand #(.WIDTH(8)) dut8 (
    .CLK (clk),
    .RST (rst),
`ifdef DFF_NAND_CE_EN
    .CE  (ce),
`endif
    .D   (d8),
    .Q   (q8),
    .Qp  (qp8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain register per DUT holding what Q must be.
  logic [0:0] m1;
  logic [7:0] m8;
  logic       valid = 1'b0;

  always @(posedge clk) begin
`ifdef DFF_NAND_CE_EN
    m1 <= rst ? 1'b0 : (ce ? d1 : m1);
    m8 <= rst ? 8'h00 : (ce ? d8 : m8);
`else
    m1 <= rst ? 1'b0 : d1;
    m8 <= rst ? 8'h00 : d8;
`endif
    valid <= 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare on every clock transition, 1 time unit after it.
  always begin
    @(clk);
    #1;
    if (valid) begin
      chk("model_q1",  {7'd0, q1},  {7'd0, m1});
      chk("model_qp1", {7'd0, qp1}, {7'd0, ~m1});
      chk("model_q8",  q8,  m8);
      chk("model_qp8", qp8, ~m8);
    end
  end

  // Drive inputs in the low phase, then return 1 unit after the rising edge.
  task automatic step(input logic r, input logic [0:0] a1, input logic [7:0] a8);
    @(negedge clk);
    #2;
    rst = r;
    d1  = a1;
    d8  = a8;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    d1  = 1'b0;
    d8  = 8'h00;
`ifdef DFF_NAND_CE_EN
    ce  = 1'b1;
`endif

    // Reset with D high
    step(1'b1, 1'b1, 8'hFF);
    chk("rst_q1",  {7'd0, q1},  8'h00);
    chk("rst_qp1", {7'd0, qp1}, 8'h01);
    chk("rst_q8",  q8,  8'h00);
    chk("rst_qp8", qp8, 8'hFF);

    step(1'b0, 1'b1, 8'hA5);
    chk("cap1_q1",  {7'd0, q1},  8'h01);
    chk("cap1_qp1", {7'd0, qp1}, 8'h00);
    chk("cap1_q8",  q8,  8'hA5);
    chk("cap1_qp8", qp8, 8'h5A);

    step(1'b0, 1'b0, 8'h3C);
    chk("cap2_q1",  {7'd0, q1},  8'h00);
    chk("cap2_qp1", {7'd0, qp1}, 8'h01);
    chk("cap2_q8",  q8,  8'h3C);
    chk("cap2_qp8", qp8, 8'hC3);

    step(1'b0, 1'b1, 8'h3C);
    chk("cap3_q1",  {7'd0, q1},  8'h01);
    chk("cap3_qp1", {7'd0, qp1}, 8'h00);

    // Falling-edge immunity: D drops while CLK is high
    #1;
    d1 = 1'b0;
    @(negedge clk);
    #1;
    chk("fall_hold_q1", {7'd0, q1}, 8'h01);
    @(posedge clk);
    #1;
    chk("fall_next_q1", {7'd0, q1}, 8'h00);

    // Mid-cycle reset
    step(1'b0, 1'b1, 8'h81);
    chk("mid_pre_q1", {7'd0, q1}, 8'h01);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_hold_q1", {7'd0, q1}, 8'h01);
    chk("mid_hold_q8", q8, 8'h81);
    @(posedge clk);
    #1;
    chk("mid_rst_q1", {7'd0, q1}, 8'h00);
    chk("mid_rst_q8", q8, 8'h00);
    step(1'b0, 1'b1, 8'h7E);
    chk("mid_rel_q1", {7'd0, q1}, 8'h01);
    chk("mid_rel_q8", q8, 8'h7E);

`ifdef DFF_NAND_CE_EN
    step(1'b1, 1'b0, 8'h00);
    @(negedge clk); #2; ce = 1'b0;
    step(1'b0, 1'b1, 8'hF0);
    chk("ce_off_q1", {7'd0, q1}, 8'h00);
    chk("ce_off_q8", q8, 8'h00);
    @(negedge clk); #2; ce = 1'b1;
    step(1'b0, 1'b1, 8'hF0);
    chk("ce_on_q1", {7'd0, q1}, 8'h01);
    chk("ce_on_q8", q8, 8'hF0);
    @(negedge clk); #2; ce = 1'b0;
    step(1'b1, 1'b1, 8'hF0);
    chk("ce_rst_q1", {7'd0, q1}, 8'h00);
    chk("ce_rst_q8", q8, 8'h00);
`endif

    // Mixed vectors checked against the model only
    for (int i = 0; i < 40; i++) begin
`ifdef DFF_NAND_CE_EN
      @(negedge clk); #2; ce = 1'($urandom_range(0, 1));
`endif
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
